// File: rtl/chs_pkg.sv
// Shared types and constants for the cool/heat actuator controller.
package chs_pkg;

  localparam int CHS_PWR_W = 5;
  localparam logic [CHS_PWR_W-1:0] CHS_PWR_MAX = 5'd31;

  localparam logic CHS_COOL = 1'b0;
  localparam logic CHS_HEAT = 1'b1;

  // Actuator FSM states; IDLE and DEAD both hold power at zero.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DEAD  = 2'd3
  } chs_state_e;

  // One ramp step from cur toward tgt; never overshoots, so it cannot wrap.
  function automatic logic [CHS_PWR_W-1:0] step_toward(
    input logic [CHS_PWR_W-1:0] cur,
    input logic [CHS_PWR_W-1:0] tgt
  );
    logic [CHS_PWR_W-1:0] res;
    res = cur;
    if (cur < tgt && cur != CHS_PWR_MAX) begin
      res = cur + 1'b1;
    end else if (cur > tgt && cur != '0) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/chs_actuator_ctrl_if.sv
// Signal bundle between the decision logic and the actuator controller.
// There is no valid/ready handshake: every input is a level, sampled on every
// rising clock edge, and every output is a level that is meaningful each cycle.
interface chs_actuator_ctrl_if;
  import chs_pkg::*;

  logic                 enable;
  logic [CHS_PWR_W-1:0] chs_power;
  logic                 chs_mode;
  logic                 cool_pwm;
  logic                 heat_pwm;
  logic [CHS_PWR_W-1:0] cur_power;
  logic                 cur_mode;
  logic                 busy;
  chs_state_e           dbg_state;

  modport master (
    output enable, chs_power, chs_mode,
    input  cool_pwm, heat_pwm, cur_power, cur_mode, busy, dbg_state
  );

  modport slave (
    input  enable, chs_power, chs_mode,
    output cool_pwm, heat_pwm, cur_power, cur_mode, busy, dbg_state
  );

endinterface

// File: rtl/chs_pwm_gen.sv
// Free-running 31-cycle PWM counter and duty comparator.
module chs_pwm_gen
  import chs_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CHS_PWR_W-1:0] i_cur_power,
  output logic                 o_pwm_on
);

  localparam logic [CHS_PWR_W-1:0] PWM_LAST = CHS_PWR_MAX - 5'd1;

  logic [CHS_PWR_W-1:0] r_pwm_cnt;

  // Count 0..30 and wrap, so power 31 is on for the whole period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt == PWM_LAST) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  assign o_pwm_on = (r_pwm_cnt < i_cur_power);

endmodule

// File: rtl/chs_actuator_ctrl.sv
// Ramped, direction-safe PWM drive for the cooler and heater.
module chs_actuator_ctrl
  import chs_pkg::*;
#(
  parameter int RAMP_DIV = 16,
  parameter int DEAD_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  chs_actuator_ctrl_if.slave bus
);

  localparam int PRE_W  = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

  logic [CHS_PWR_W-1:0] r_tgt_power;
  logic                 r_tgt_mode;
  logic [PRE_W-1:0]     r_presc;
  chs_state_e           r_state;
  logic [CHS_PWR_W-1:0] r_cur_power;
  logic                 r_cur_mode;
  logic [DEAD_W-1:0]    r_dead_cnt;
  logic                 r_cool_pwm;
  logic                 r_heat_pwm;

  chs_state_e           w_state_nxt;
  logic [CHS_PWR_W-1:0] w_power_nxt;
  logic                 w_mode_nxt;
  logic [DEAD_W-1:0]    w_dead_nxt;
  logic                 w_tick;
  logic                 w_mismatch;
  logic                 w_pwm_on;
  logic                 w_drive;

  // Register the requests; a disabled controller targets zero power.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt_power <= '0;
      r_tgt_mode  <= CHS_COOL;
    end else begin
      r_tgt_power <= bus.enable ? bus.chs_power : '0;
      r_tgt_mode  <= bus.chs_mode;
    end
  end

  // Ramp prescaler, free-running from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (r_presc == PRE_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick     = (r_presc == PRE_LAST);
  // A zero target never asks for a direction change.
  assign w_mismatch = (r_tgt_power != '0) && (r_tgt_mode != r_cur_mode);

  // FSM state, applied power/direction and dead-time counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cur_power <= '0;
      r_cur_mode  <= CHS_COOL;
      r_dead_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_power <= w_power_nxt;
      r_cur_mode  <= w_mode_nxt;
      r_dead_cnt  <= w_dead_nxt;
    end
  end

  // Next-state logic: ramp in RUN, drain to zero and wait out dead time on a
  // direction change; a cleared mismatch during DRAIN resumes RUN directly.
  always_comb begin
    w_state_nxt = r_state;
    w_power_nxt = r_cur_power;
    w_mode_nxt  = r_cur_mode;
    w_dead_nxt  = r_dead_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_mismatch) begin
          w_state_nxt = ST_DEAD;
          w_dead_nxt  = '0;
        end else if (r_tgt_power != '0) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_mismatch) begin
          w_state_nxt = ST_DRAIN;
        end else if (r_cur_power == '0 && r_tgt_power == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          w_power_nxt = step_toward(r_cur_power, r_tgt_power);
        end
      end
      ST_DRAIN: begin
        if (!w_mismatch) begin
          w_state_nxt = ST_RUN;
        end else if (r_cur_power == '0) begin
          w_state_nxt = ST_DEAD;
          w_dead_nxt  = '0;
        end else if (w_tick) begin
          w_power_nxt = r_cur_power - 1'b1;
          if (r_cur_power == CHS_PWR_W'(1)) begin
            w_state_nxt = ST_DEAD;
            w_dead_nxt  = '0;
          end
        end
      end
      ST_DEAD: begin
        // The dead interval always runs to completion before the flip.
        if (r_dead_cnt == DEAD_LAST) begin
          w_mode_nxt  = r_tgt_mode;
          w_state_nxt = ST_RUN;
        end else begin
          w_dead_nxt = r_dead_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  chs_pwm_gen u_pwm_gen (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cur_power (r_cur_power),
    .o_pwm_on    (w_pwm_on)
  );

  assign w_drive = w_pwm_on && (r_state == ST_RUN || r_state == ST_DRAIN);

  // Registered drives; steering by a single mode bit keeps them exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cool_pwm <= 1'b0;
      r_heat_pwm <= 1'b0;
    end else begin
      r_cool_pwm <= w_drive & (r_cur_mode == CHS_COOL);
      r_heat_pwm <= w_drive & (r_cur_mode == CHS_HEAT);
    end
  end

  assign bus.cool_pwm  = r_cool_pwm;
  assign bus.heat_pwm  = r_heat_pwm;
  assign bus.cur_power = r_cur_power;
  assign bus.cur_mode  = r_cur_mode;
  assign bus.dbg_state = r_state;
  assign bus.busy      = (r_cur_power != r_tgt_power) || w_mismatch ||
                         (r_state == ST_DRAIN) || (r_state == ST_DEAD);

endmodule

// File: tb/tb_chs_actuator_ctrl.sv
// Self-checking bench for chs_actuator_ctrl with a cycle-level reference model.
module tb_chs_actuator_ctrl;
  import chs_pkg::*;

  localparam int RD  = 4;
  localparam int DC  = 3;
  localparam int PER = 31;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  chs_actuator_ctrl_if bus ();

  chs_actuator_ctrl #(.RAMP_DIV(RD), .DEAD_CYC(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int err_cnt = 0;
  int chk_cnt = 0;
  logic [10:0] exp_q[$];

  chs_state_e m_ph;
  int m_k, m_tp, m_tm, m_pow, m_mode, m_dl, m_cool, m_heat;

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = ST_IDLE; m_k = 0; m_tp = 0; m_tm = 0;
    m_pow = 0; m_mode = 0; m_dl = 0; m_cool = 0; m_heat = 0;
  endtask

  // Behaviour across one rising edge, computed from the pre-edge model values.
  task automatic model_edge();
    int  pw;
    bit  tick, mism, on;
    m_k++;
    pw   = (m_k - 1) % PER;
    tick = ((m_k - 1) % RD) == (RD - 1);
    on   = (pw < m_pow) && (m_ph == ST_RUN || m_ph == ST_DRAIN);
    m_cool = (on && m_mode == 0) ? 1 : 0;
    m_heat = (on && m_mode == 1) ? 1 : 0;
    mism = (m_tp != 0) && (m_tm != m_mode);
    case (m_ph)
      ST_IDLE: begin
        if (mism) begin m_ph = ST_DEAD; m_dl = DC; end
        else if (m_tp != 0) m_ph = ST_RUN;
      end
      ST_RUN: begin
        if (mism) m_ph = ST_DRAIN;
        else if (m_pow == 0 && m_tp == 0) m_ph = ST_IDLE;
        else if (tick) m_pow = m_pow + ((m_tp > m_pow) ? 1 : (m_tp < m_pow) ? -1 : 0);
      end
      ST_DRAIN: begin
        if (!mism) m_ph = ST_RUN;
        else if (m_pow == 0) begin m_ph = ST_DEAD; m_dl = DC; end
        else if (tick) begin
          m_pow = m_pow - 1;
          if (m_pow == 0) begin m_ph = ST_DEAD; m_dl = DC; end
        end
      end
      default: begin
        m_dl = m_dl - 1;
        if (m_dl == 0) begin m_mode = m_tm; m_ph = ST_RUN; end
      end
    endcase
    m_tp = bus.enable ? int'(bus.chs_power) : 0;
    m_tm = int'(bus.chs_mode);
  endtask

  function automatic logic [10:0] model_word();
    bit busy;
    busy = (m_pow != m_tp) || (m_tp != 0 && m_tm != m_mode) ||
           (m_ph == ST_DRAIN) || (m_ph == ST_DEAD);
    return {m_ph, busy, m_heat[0], m_cool[0], m_mode[0], m_pow[4:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit en, input int pwr, input bit md);
    bus.enable    = en;
    bus.chs_power = 5'(pwr);
    bus.chs_mode  = md;
  endtask

  // One clock: advance the model at the edge, compare shortly after it.
  task automatic step();
    logic [10:0] e;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    exp_q.push_back(model_word());
    #1;
    e = exp_q.pop_front();
    check("state",     int'(bus.dbg_state), int'(e[10:9]));
    check("busy",      int'(bus.busy),      int'(e[8]));
    check("heat_pwm",  int'(bus.heat_pwm),  int'(e[7]));
    check("cool_pwm",  int'(bus.cool_pwm),  int'(e[6]));
    check("cur_mode",  int'(bus.cur_mode),  int'(e[5]));
    check("cur_power", int'(bus.cur_power), int'(e[4:0]));
    check("no_overlap", int'(bus.cool_pwm & bus.heat_pwm), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_power"}, int'(bus.cur_power), 0);
    check({tag, "_mode"},  int'(bus.cur_mode),  0);
    check({tag, "_cool"},  int'(bus.cool_pwm),  0);
    check({tag, "_heat"},  int'(bus.heat_pwm),  0);
    check({tag, "_busy"},  int'(bus.busy),      0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int prev, changes, last_k, gap, cnt_cool, cnt_heat, dead_cyc, dead_pwm, drains;
    model_reset();
    drive(1'b1, 17, 1'b1);
    #1 rst_n = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      step();
    end
    check_all_zero("reset_hold");
    drive(1'b0, 9, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("idle_after_release", int'(bus.dbg_state), int'(ST_IDLE));
    check("idle_busy", int'(bus.busy), 0);

    // Ramp-up to cool 5: one step every RD cycles.
    drive(1'b1, 5, 1'b0);
    prev = 0; changes = 0; last_k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (int'(bus.cur_power) != prev) begin
        if (changes > 0) begin
          gap = m_k - last_k;
          check("ramp_step_gap", gap, RD);
        end
        changes++; last_k = m_k; prev = int'(bus.cur_power);
      end
    end
    check("ramp5_steps", changes, 5);
    check("ramp5_busy", int'(bus.busy), 0);
    cnt_cool = 0; cnt_heat = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      cnt_cool += int'(bus.cool_pwm);
      cnt_heat += int'(bus.heat_pwm);
    end
    check("duty5_cool", cnt_cool, 5);
    check("duty5_heat", cnt_heat, 0);

    // Full scale, then back to zero.
    drive(1'b1, 31, 1'b0);
    changes = 0; prev = int'(bus.cur_power);
    for (int i = 0; i < 31 * RD + 8 && int'(bus.cur_power) != 31; i++) begin
      step();
      if (int'(bus.cur_power) != prev) begin changes++; prev = int'(bus.cur_power); end
    end
    check("full_reached", int'(bus.cur_power), 31);
    check("full_ticks", changes, 31 - 5);
    step(); step();
    cnt_cool = 0;
    for (int i = 0; i < PER; i++) begin step(); cnt_cool += int'(bus.cool_pwm); end
    check("full_cool_const", cnt_cool, PER);
    drive(1'b1, 0, 1'b0);
    for (int i = 0; i < 31 * RD + 8 && bus.dbg_state != ST_IDLE; i++) step();
    check("down_idle", int'(bus.dbg_state), int'(ST_IDLE));
    cnt_cool = 0;
    for (int i = 0; i < PER; i++) begin step(); cnt_cool += int'(bus.cool_pwm); end
    check("down_cool_zero", cnt_cool, 0);

    // Direction change cool 5 -> heat 10.
    drive(1'b1, 5, 1'b0);
    for (int i = 0; i < 60 && !(int'(bus.cur_power) == 5 && !bus.busy); i++) step();
    check("dir_pre_power", int'(bus.cur_power), 5);
    drive(1'b1, 10, 1'b1);
    drains = 0; dead_cyc = 0; dead_pwm = 0; prev = 5;
    for (int i = 0; i < 200 && !(int'(bus.cur_power) == 10 && !bus.busy); i++) begin
      step();
      if (bus.cur_mode == 1'b0 && int'(bus.cur_power) < prev) drains++;
      if (bus.dbg_state == ST_DEAD) begin
        dead_cyc++;
        dead_pwm += int'(bus.cool_pwm) + int'(bus.heat_pwm);
      end
      prev = int'(bus.cur_power);
    end
    check("dir_drain_ticks", drains, 5);
    check("dir_dead_cycles", dead_cyc, DC);
    check("dir_dead_pwm", dead_pwm, 0);
    check("dir_mode_heat", int'(bus.cur_mode), 1);
    check("dir_power10", int'(bus.cur_power), 10);

    // Back to cool 5, then abort a drain at power 3.
    drive(1'b1, 5, 1'b0);
    for (int i = 0; i < 300 && !(int'(bus.cur_power) == 5 && !bus.busy); i++) step();
    check("abort_pre_mode", int'(bus.cur_mode), 0);
    drive(1'b1, 5, 1'b1);
    for (int i = 0; i < 60 && !(bus.dbg_state == ST_DRAIN && int'(bus.cur_power) == 3); i++) step();
    check("abort_at3", int'(bus.cur_power), 3);
    drive(1'b1, 5, 1'b0);
    dead_cyc = 0;
    for (int i = 0; i < 8 && bus.dbg_state != ST_RUN; i++) begin
      step();
      if (bus.dbg_state == ST_DEAD) dead_cyc++;
    end
    check("abort_run", int'(bus.dbg_state), int'(ST_RUN));
    check("abort_no_dead", dead_cyc, 0);
    check("abort_mode", int'(bus.cur_mode), 0);

    // Enable drop mid-ramp at power 4.
    drive(1'b1, 0, 1'b0);
    for (int i = 0; i < 60 && bus.dbg_state != ST_IDLE; i++) step();
    drive(1'b1, 8, 1'b0);
    for (int i = 0; i < 40 && int'(bus.cur_power) != 4; i++) step();
    check("en_drop_at4", int'(bus.cur_power), 4);
    drive(1'b0, 8, 1'b0);
    for (int i = 0; i < 40 && bus.dbg_state != ST_IDLE; i++) step();
    check("en_drop_idle", int'(bus.dbg_state), int'(ST_IDLE));
    check("en_drop_power", int'(bus.cur_power), 0);

    // Randomized segments against the model.
    for (int s = 0; s < 25; s++) begin
      drive(1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) step();
    end

    // Asynchronous reset in the middle of a drain.
    drive(1'b1, 5, 1'b0);
    for (int i = 0; i < 400 && !(int'(bus.cur_power) == 5 && !bus.busy); i++) step();
    check("rst_pre_power", int'(bus.cur_power), 5);
    drive(1'b1, 10, 1'b1);
    for (int i = 0; i < 40 && !(bus.dbg_state == ST_DRAIN && int'(bus.cur_power) < 5); i++) step();
    check("rst_in_drain", int'(bus.dbg_state), int'(ST_DRAIN));
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    check("rst_async_state", int'(bus.dbg_state), int'(ST_IDLE));
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("rst_resume_mode", int'(bus.cur_mode), 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/chs_actuator_ctrl.md
# chs_actuator_ctrl

Downstream stage of the cool/heat-system decision logic. Consumes the 5-bit power request `chs_power` and direction bit `chs_mode`, and drives the physical cooler and heater through PWM outputs. Ramps power one step at a time, and enforces a drain-to-zero plus dead-time interval before the direction changes. The cooler and heater are never driven at the same time.

## Interface

Parameters:
- `RAMP_DIV`, default 16: clock cycles per ramp step (≥2).
- `DEAD_CYC`, default 8: dead-time cycles at zero power before a direction change (≥1).

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 0 forces target power to 0.
- `chs_power` in 5: requested power, 0..31.
- `chs_mode` in 1: requested direction; 0 = cool, 1 = heat.
- `cool_pwm` out 1: cooler drive.
- `heat_pwm` out 1: heater drive.
- `cur_power` out 5: applied power level.
- `cur_mode` out 1: applied direction.
- `busy` out 1: high while `cur_power`/`cur_mode` differ from the target, or while in DRAIN/DEAD.

## Operation

- Inputs are registered once each cycle into `tgt_power` and `tgt_mode`. When `enable` = 0, `tgt_power` = 0.
- Mode mismatch is defined as `tgt_power != 0 && tgt_mode != cur_mode`. A zero target never requests a direction change, so `cur_mode` holds.
- The prescaler counts 0..`RAMP_DIV`-1 freely from reset. `tick` is asserted on the cycle the count equals `RAMP_DIV`-1.
- FSM states are IDLE, RUN, DRAIN and DEAD. Reset state is IDLE.
  - IDLE (`cur_power` = 0):
    - If there is a mismatch, go to DEAD.
    - Else if `tgt_power` != 0, go to RUN.
  - RUN: on each `tick`, `cur_power` moves ±1 toward `tgt_power`.
    - A mismatch moves the FSM to DRAIN.
    - If `cur_power` = 0 and `tgt_power` = 0, go to IDLE.
  - DRAIN: on each `tick`, `cur_power` decrements by 1.
    - If the mismatch clears, return to RUN with no dead time.
    - When `cur_power` reaches 0, go to DEAD.
  - DEAD: counts `DEAD_CYC` cycles at zero power.
    - On exit, latch `cur_mode` ← `tgt_mode` and go to RUN.
    - The count always completes, even if the mismatch clears during it.
- `cur_power` saturates at 0 and 31 and never wraps.
- PWM:
  - `pwm_cnt` is a 5-bit counter over 0..30 (period 31 cycles) that wraps 30→0.
  - `pwm_on` = `pwm_cnt < cur_power`. Power 0 is always off; power 31 is always on.
  - `cool_pwm` = `pwm_on & ~cur_mode`; `heat_pwm` = `pwm_on & cur_mode`. Both are registered.
  - Both PWM outputs are 0 in IDLE and DEAD.
- Reset values: `cur_power` = 0, `cur_mode` = 0, `cool_pwm` = 0, `heat_pwm` = 0, `busy` = 0, prescaler = 0, `pwm_cnt` = 0.

## Timing

- Input-to-target latency is 1 cycle. A ramp step then takes effect on the next `tick`, at most `RAMP_DIV` cycles later.
- A full-scale ramp 0→31 takes 31 ticks.
- A direction change from power P takes P ticks of drain, plus `DEAD_CYC` cycles in DEAD, plus the ramp-up.
- PWM outputs lag `cur_power`/`cur_mode` by 1 cycle.
- Required invariant: `cool_pwm` & `heat_pwm` is never 1 in any cycle.
- `rst_n` low at any point, including mid-DRAIN or mid-DEAD, asynchronously clears all outputs to their reset values.
- After `rst_n` deasserts, operation resumes from IDLE at the next `clk`.

## Structure

- Shared package `chs_pkg`:
  - FSM state encoding (IDLE/RUN/DRAIN/DEAD).
  - `CHS_PWR_W` = 5 and `CHS_PWR_MAX` = 31.
  - Mode constants `CHS_COOL` = 0 and `CHS_HEAT` = 1.
- One sub-module, `chs_pwm_gen`: the `pwm_cnt` counter plus the comparator, taking `cur_power` and returning `pwm_on`.
- The FSM, prescaler and dead-time counter stay in the top module.

## Test plan

All scenarios use `RAMP_DIV`=4 and `DEAD_CYC`=3.
- Reset: hold `rst_n`=0 with random inputs → all outputs 0. Release with `enable`=0 → stays in IDLE, `busy`=0.
- Ramp-up: `enable`=1, mode 0, power 5 → `cur_power` steps 1..5, one step per 4 cycles. Steady state: `cool_pwm` high 5 of every 31 cycles, `heat_pwm` 0, `busy` falls.
- Full scale: power 31 in cool → after 31 ticks `cool_pwm` is constant 1. Power 0 → ramps back down, returns to IDLE, `cool_pwm` constant 0.
- Direction change: at steady cool power 5, apply mode 1 with power 10:
  - `cur_power` 5→0 over 5 ticks.
  - Both PWM outputs 0 for exactly 3 DEAD cycles.
  - `cur_mode`=1, then ramp to 10.
  - The overlap checker never fires.
- Aborted drain: during DRAIN at power 3, return `chs_mode` to 0 → FSM back in RUN with no DEAD entry; `cur_mode` stays 0.
- Enable drop and reset: `enable`=0 mid-ramp at power 4 → ramps to 0 and enters IDLE. Separately, asserting `rst_n` mid-DRAIN clears all outputs in the same cycle, with no clock required.
